synch_write_fifo: RTL

- Buffers data in the 133 MHz domain, directly downstream of write_synchronizer.
- Converts each synchronized write level (write_synch) into exactly one FIFO write of the source-held data word.
- Lets the local consumer pop words with a read strobe.
- Reports full, empty, occupancy count, and sticky overflow/underflow errors.

---
 rtl/synch_write_fifo.sv | 72 +++++++
 1 files changed

// File: rtl/synch_write_fifo.sv
// synch_write_fifo: edge-detected write FIFO with registered read data, occupancy count and sticky error flags
module synch_write_fifo #(
  parameter int word_size = 8,
  parameter int ptr_size  = 3,
  parameter int depth     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_synch,
  input  logic [word_size-1:0] data_in,
  input  logic                 read_from_FIFO,
  output logic [word_size-1:0] data_out,
  output logic                 data_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [ptr_size:0]    count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam logic [ptr_size:0]   full_c  = (ptr_size+1)'(depth);
  localparam logic [ptr_size:0]   one_c   = 1;
  localparam logic [ptr_size-1:0] ptr_one = 1;
  logic [word_size-1:0] mem [2**ptr_size];
  logic                 write_synch_q;
  logic [ptr_size-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ptr_size:0]    count_q, count_d;
  logic [word_size-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic                 write_req, rd_acc, wr_acc;
  assign fifo_full  = count_q == full_c;
  assign fifo_empty = count_q == '0;
  assign write_req  = write_synch & ~write_synch_q;
  assign rd_acc     = read_from_FIFO & ~fifo_empty;
  // a full FIFO can still take a write when a read frees a slot in the same cycle
  assign wr_acc     = write_req & (~fifo_full | rd_acc);
  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + ptr_one : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + ptr_one : rd_ptr_q;
    count_d     = (wr_acc & ~rd_acc) ? count_q + one_c :
                  (rd_acc & ~wr_acc) ? count_q - one_c : count_q;
    data_out_d  = rd_acc ? mem[rd_ptr_q] : data_out_q;
    overflow_d  = overflow_q | (write_req & ~wr_acc);
    underflow_d = underflow_q | (read_from_FIFO & fifo_empty);
  end
  // the edge detector keeps tracking through reset so a held level never writes
  always_ff @(posedge clock) write_synch_q <= write_synch;
  always_ff @(posedge clock) if (wr_acc && !reset) mem[wr_ptr_q] <= data_in;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= rd_acc;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end
  assign count      = count_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
endmodule
